// File: rtl/fwd_hazard_unit.sv
// Operand forwarding select and load-use stall controller for a 5-stage pipeline.
// Optional statistics counters are compiled in with `define FWD_HAZARD_STATS_EN.
module fwd_hazard_unit #(
  parameter int NUM_SRC  = 2,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [NUM_SRC*REG_AW-1:0]   i_rs_IFID,
  input  logic [NUM_SRC-1:0]          i_rs_used_IFID,
  input  logic [NUM_SRC*REG_AW-1:0]   i_rs_IDEX,
  input  logic [REG_AW-1:0]           i_rd_IDEX,
  input  logic [REG_AW-1:0]           i_rd_EXMEM,
  input  logic [REG_AW-1:0]           i_rd_MEMWB,
  input  logic                        i_clu_RegWrite_IDEX,
  input  logic                        i_clu_RegWrite_EXMEM,
  input  logic                        i_clu_RegWrite_MEMWB,
  input  logic                        i_clu_MemRead_IDEX,
  input  logic                        i_flush,
  output logic [2*NUM_SRC-1:0]        o_forward,
  output logic                        o_stall_IF,
  output logic                        o_stall_ID,
  output logic                        o_bubble_EX,
  output logic [31:0]                 o_stall_cycles,
  output logic [31:0]                 o_fwd_events
);

  // state | meaning
  // IDLE  | no stall in progress; load-use hazards are detected here
  // STALL | extra stall cycles of a multi-cycle load-use stall; cnt counts down
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] STALL = 1'b1;
  localparam logic [1:0] CNT_INIT = 2'(LOAD_LAT - 1);

  logic [0:0] state;
  logic [1:0] cnt;
  logic       hazard;
  logic       stall;

  always_comb begin
    o_forward = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (i_clu_RegWrite_EXMEM && (i_rd_EXMEM != '0) &&
          (i_rd_EXMEM == i_rs_IDEX[k*REG_AW +: REG_AW]))
        o_forward[2*k +: 2] = 2'b10;
      else if (i_clu_RegWrite_MEMWB && (i_rd_MEMWB != '0) &&
               (i_rd_MEMWB == i_rs_IDEX[k*REG_AW +: REG_AW]))
        o_forward[2*k +: 2] = 2'b01;
    end
  end

  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (i_rs_used_IFID[k] && (i_rs_IFID[k*REG_AW +: REG_AW] == i_rd_IDEX))
        hazard = 1'b1;
    end
    hazard = hazard & i_clu_MemRead_IDEX & i_clu_RegWrite_IDEX & (i_rd_IDEX != '0);
  end

  // Gated by reset so the stall drops the instant reset asserts.
  assign stall       = i_rst_n & ~i_flush & ((state == STALL) | hazard);
  assign o_stall_IF  = stall;
  assign o_stall_ID  = stall;
  assign o_bubble_EX = stall;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else if (i_flush) begin
      state <= IDLE;
      cnt   <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (hazard && (LOAD_LAT > 1)) begin
            state <= STALL;
            cnt   <= CNT_INIT;
          end
        end
        STALL: begin
          cnt <= cnt - 2'd1;
          if (cnt == 2'd1) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

`ifdef FWD_HAZARD_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] fwd_events;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cycles <= '0;
      fwd_events   <= '0;
    end else begin
      if (stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if ((o_forward != '0) && (fwd_events != 32'hFFFF_FFFF))
        fwd_events <= fwd_events + 32'd1;
    end
  end

  assign o_stall_cycles = stall_cycles;
  assign o_fwd_events   = fwd_events;
`else
  assign o_stall_cycles = 32'd0;
  assign o_fwd_events   = 32'd0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: directed corner cases followed by random traffic
// compared against a cycle-level reference model of forwarding and stalling.
module tb_fwd_hazard_unit;
  localparam int NUM_SRC  = 2;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 3;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_SRC*REG_AW-1:0] rs_ifid;
  logic [NUM_SRC-1:0]        rs_used_ifid;
  logic [NUM_SRC*REG_AW-1:0] rs_idex;
  logic [REG_AW-1:0]         rd_idex, rd_exmem, rd_memwb;
  logic                      wr_idex, wr_exmem, wr_memwb, memrd_idex, flush;
  logic [2*NUM_SRC-1:0]      fwd;
  logic                      stall_if, stall_id, bubble_ex;
  logic [31:0]               stall_cycles, fwd_events;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  int remaining = 0;
  int n_stall = 0;
  int n_fwd = 0;

  fwd_hazard_unit #(.NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs_IFID(rs_ifid), .i_rs_used_IFID(rs_used_ifid), .i_rs_IDEX(rs_idex),
    .i_rd_IDEX(rd_idex), .i_rd_EXMEM(rd_exmem), .i_rd_MEMWB(rd_memwb),
    .i_clu_RegWrite_IDEX(wr_idex), .i_clu_RegWrite_EXMEM(wr_exmem),
    .i_clu_RegWrite_MEMWB(wr_memwb), .i_clu_MemRead_IDEX(memrd_idex),
    .i_flush(flush), .o_forward(fwd), .o_stall_IF(stall_if), .o_stall_ID(stall_id),
    .o_bubble_EX(bubble_ex), .o_stall_cycles(stall_cycles), .o_fwd_events(fwd_events)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int src(input logic [NUM_SRC*REG_AW-1:0] v, input int s);
    return int'((v >> (s * REG_AW)) % (1 << REG_AW));
  endfunction

  function automatic logic [2*NUM_SRC-1:0] model_fwd();
    logic [2*NUM_SRC-1:0] r = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      int reg_idx = src(rs_idex, s);
      int sel = 0;
      if (wr_exmem && rd_exmem != 0 && int'(rd_exmem) == reg_idx) sel = 2;
      else if (wr_memwb && rd_memwb != 0 && int'(rd_memwb) == reg_idx) sel = 1;
      r = r | (2*NUM_SRC)'(sel << (2 * s));
    end
    return r;
  endfunction

  function automatic bit model_hazard();
    bit hit = 0;
    for (int s = 0; s < NUM_SRC; s++)
      if (rs_used_ifid[s] && src(rs_ifid, s) == int'(rd_idex)) hit = 1;
    return hit && memrd_idex && wr_idex && rd_idex != 0;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef FWD_HAZARD_STATS_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n - n);
`endif
  endfunction

  // Called 1 time unit after a rising edge; checks mid-cycle, advances the model at the edge.
  task automatic cycle(output logic st_seen, output logic [2*NUM_SRC-1:0] fw_seen);
    logic                 exp_st;
    logic [2*NUM_SRC-1:0] exp_fw;
    bit                   hz;
    exp_fw = model_fwd();
    hz     = model_hazard();
    exp_st = (remaining > 0) ? !flush : (hz && !flush);
    #3;
    check("forward", {60'd0, fwd}, {60'd0, exp_fw});
    check("stall_IF", {63'd0, stall_if}, {63'd0, exp_st});
    check("stall_ID", {63'd0, stall_id}, {63'd0, exp_st});
    check("bubble_EX", {63'd0, bubble_ex}, {63'd0, exp_st});
    check("stall_cycles", {32'd0, stall_cycles}, {32'd0, exp_cnt(n_stall)});
    check("fwd_events", {32'd0, fwd_events}, {32'd0, exp_cnt(n_fwd)});
    st_seen = stall_if;
    fw_seen = fwd;
    @(posedge clk);
    if (flush) remaining = 0;
    else if (remaining > 0) remaining--;
    else if (hz) remaining = LOAD_LAT - 1;
    if (exp_st) n_stall++;
    if (exp_fw != 0) n_fwd++;
    #1;
  endtask

  task automatic clear_inputs();
    rs_ifid = '0; rs_used_ifid = '0; rs_idex = '0;
    rd_idex = '0; rd_exmem = '0; rd_memwb = '0;
    wr_idex = 0; wr_exmem = 0; wr_memwb = 0; memrd_idex = 0; flush = 0;
  endtask

  task automatic load_rd7_slot1(input logic used);
    rd_idex = 5'd7; wr_idex = 1; memrd_idex = 1;
    rs_ifid = {5'd7, 5'd2};
    rs_used_ifid = {used, 1'b1};
  endtask

  logic                 st;
  logic [2*NUM_SRC-1:0] fw;

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #2;
    load_rd7_slot1(1'b1);
    #1;
    check("reset_stall", {63'd0, stall_if}, 64'd0);
    check("reset_bubble", {63'd0, bubble_ex}, 64'd0);
    check("reset_stall_cycles", {32'd0, stall_cycles}, 64'd0);
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // EXMEM wins over MEMWB on the same register
    rs_idex = {5'd1, 5'd5}; rd_exmem = 5'd5; rd_memwb = 5'd5; wr_exmem = 1; wr_memwb = 1;
    cycle(st, fw);
    check("fwd_exmem_priority", {62'd0, fw[1:0]}, 64'd2);

    // register 0 never forwards even with RegWrite set
    clear_inputs();
    rs_idex = {5'd3, 5'd0}; rd_exmem = 5'd0; wr_exmem = 1; rd_memwb = 5'd3; wr_memwb = 1;
    cycle(st, fw);
    check("fwd_r0_slot0", {62'd0, fw[1:0]}, 64'd0);
    check("fwd_memwb_slot1", {62'd0, fw[3:2]}, 64'd1);

    // load-use: exactly LOAD_LAT stall cycles
    clear_inputs();
    load_rd7_slot1(1'b1);
    cycle(st, fw);
    check("lu_stall_c0", {63'd0, st}, 64'd1);
    clear_inputs();
    for (int i = 1; i < LOAD_LAT; i++) begin
      cycle(st, fw);
      check("lu_stall_cN", {63'd0, st}, 64'd1);
    end
    cycle(st, fw);
    check("lu_stall_end", {63'd0, st}, 64'd0);

    // unused slot does not cause a stall
    load_rd7_slot1(1'b0);
    cycle(st, fw);
    check("lu_unused_slot", {63'd0, st}, 64'd0);
    clear_inputs();

    // flush on the 2nd stall cycle
    load_rd7_slot1(1'b1);
    cycle(st, fw);
    clear_inputs();
    flush = 1;
    cycle(st, fw);
    check("flush_stall_low", {63'd0, st}, 64'd0);
    flush = 0;
    cycle(st, fw);
    check("flush_idle_after", {63'd0, st}, 64'd0);

    // reset mid-stall clears counters and stall asynchronously, stall not resumed
    load_rd7_slot1(1'b1);
    cycle(st, fw);
    clear_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", {63'd0, stall_if}, 64'd0);
    check("rst_mid_stall_cycles", {32'd0, stall_cycles}, 64'd0);
    check("rst_mid_fwd_events", {32'd0, fwd_events}, 64'd0);
    #2;
    rst_n = 1'b1;
    remaining = 0; n_stall = 0; n_fwd = 0;
    @(posedge clk);
    #1;
    cycle(st, fw);
    check("rst_no_resume", {63'd0, st}, 64'd0);

    // stall counter after exactly one hazard from a clean reset
    load_rd7_slot1(1'b1);
    cycle(st, fw);
    clear_inputs();
    for (int i = 0; i < LOAD_LAT; i++) cycle(st, fw);
    check("stall_cycles_one_hazard", {32'd0, stall_cycles}, {32'd0, exp_cnt(LOAD_LAT)});

    // random traffic on a small register range to provoke matches
    for (int n = 0; n < 400; n++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        rs_ifid[s*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
        rs_idex[s*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 7));
      end
      rs_used_ifid = NUM_SRC'($urandom);
      rd_idex  = REG_AW'($urandom_range(0, 7));
      rd_exmem = REG_AW'($urandom_range(0, 7));
      rd_memwb = REG_AW'($urandom_range(0, 7));
      wr_idex  = 1'($urandom);
      wr_exmem = 1'($urandom);
      wr_memwb = 1'($urandom);
      memrd_idex = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cycle(st, fw);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: source operands per instruction, range 1..4.
REQ-002 SHALL have parameter REG_AW, default 5: register index width.
REQ-003 SHALL have parameter LOAD_LAT, default 1: load-use stall cycles, range 1..4.
REQ-004 SHALL have port i_clk, input, 1: sole clock, rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_rs_IFID, input, NUM_SRC*REG_AW: source indices of the ID-stage instruction; slot k at [k*REG_AW +: REG_AW].
REQ-007 SHALL have port i_rs_used_IFID, input, NUM_SRC: bit k set when slot k is actually read.
REQ-008 SHALL have port i_rs_IDEX, input, NUM_SRC*REG_AW: source indices of the EX-stage instruction.
REQ-009 SHALL have ports i_rd_IDEX, i_rd_EXMEM, i_rd_MEMWB, input, REG_AW each: destination indices.
REQ-010 SHALL have ports i_clu_RegWrite_IDEX, i_clu_RegWrite_EXMEM, i_clu_RegWrite_MEMWB, input, 1 each: register write enables.
REQ-011 SHALL have port i_clu_MemRead_IDEX, input, 1: EX-stage instruction is a load.
REQ-012 SHALL have port i_flush, input, 1: pipeline flush (taken branch or jump).
REQ-013 SHALL have port o_forward, output, 2*NUM_SRC: operand mux select per slot; slot k at [2k +: 2].
REQ-014 SHALL have ports o_stall_IF and o_stall_ID, output, 1 each: hold PC and IF/ID.
REQ-015 SHALL have port o_bubble_EX, output, 1: insert NOP into ID/EX.
REQ-016 SHALL have ports o_stall_cycles and o_fwd_events, output, 32 each: statistics counters.

Function
REQ-017 SHALL drive each o_forward slot combinationally: 2'b10 when EXMEM writes, rd_EXMEM != 0 and rd_EXMEM == rs; else 2'b01 when MEMWB writes, rd_MEMWB != 0 and rd_MEMWB == rs; else 2'b00.
REQ-018 SHALL give EXMEM priority over MEMWB when both match the same slot.
REQ-019 SHALL never forward for register index 0.
REQ-020 SHALL detect a hazard when MemRead_IDEX & RegWrite_IDEX & rd_IDEX != 0 and rd_IDEX matches any slot k with i_rs_used_IFID[k] set.
REQ-021 SHALL implement FSM states IDLE and STALL, with a 2-bit down-counter cnt.
REQ-022 SHALL, in IDLE with a hazard and no flush, assert the stall outputs in that same cycle; if LOAD_LAT > 1 it SHALL go to STALL with cnt = LOAD_LAT-1, otherwise it SHALL stay in IDLE.
REQ-023 SHALL, in STALL, assert the stall outputs and decrement cnt; when cnt == 1 it SHALL return to IDLE on the next edge.
REQ-024 SHALL assert stall for exactly LOAD_LAT consecutive cycles per detected load-use hazard.
REQ-025 SHALL ignore hazard detection while in STALL; re-detection is evaluated only in IDLE.
REQ-026 SHALL always assert o_stall_IF, o_stall_ID and o_bubble_EX together.
REQ-027 SHALL give i_flush priority: stall outputs are 0 in that cycle, and the FSM goes to IDLE with cnt = 0 on the next edge, from either state.
REQ-028 SHALL keep o_forward independent of FSM state and flush.

Reset
REQ-029 SHALL, on i_rst_n low, immediately force IDLE, cnt = 0, all stall outputs 0, and both counters 0.
REQ-030 SHALL, if reset asserts mid-STALL, abandon the stall and not resume it after release.
REQ-031 SHALL drive o_forward purely from its inputs, with no reset dependency.

Configuration
REQ-032 SHALL use macro FWD_HAZARD_STATS_EN to compile the statistics counters in or out.
REQ-033 SHALL, when the macro is defined, increment o_stall_cycles each cycle the stall is asserted and o_fwd_events each cycle any o_forward slot is non-zero, both saturating at 32'hFFFFFFFF.
REQ-034 SHALL, when the macro is undefined, tie both counter outputs to 0 and instantiate no counter flops.

Verification
REQ-035 SHALL cover: rs_IDEX slot0 = 5, EXMEM and MEMWB both writing rd = 5 -> o_forward[1:0] = 2'b10.
REQ-036 SHALL cover: rd_EXMEM = 0 with RegWrite set, rs = 0, MEMWB rd = 3 -> slot forward 2'b00.
REQ-037 SHALL cover: LOAD_LAT = 3, load rd = 7 in IDEX, rs_IFID slot1 = 7 used -> stall high for exactly 3 cycles, then low.
REQ-038 SHALL cover: same load but i_rs_used_IFID[1] = 0 -> no stall.
REQ-039 SHALL cover: flush asserted on the 2nd stall cycle -> stall low that cycle and the FSM in IDLE afterward.
REQ-040 SHALL cover: with the macro defined, the sequence of REQ-037 -> o_stall_cycles = 3; reset pulse mid-stall -> counters 0 and stall low asynchronously.
